alu_secuencial: RTL

- Parametrised, clocked successor to the team's combinational case-selected ALU.
- Captures operands and opcode on a start pulse and executes the same 4-bit opcode set.
- Multiplication, division and modulo run as iterative n-cycle operations; all other ops take one cycle.
- Results and flags are registered and announced with a one-cycle done pulse; the block sits between the datapath register file and the flag/status logic.

---
 rtl/alu_secuencial.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_secuencial.sv
// Clocked, parametrised ALU: captures operands on a start pulse and announces registered results
// with a one-cycle done pulse. Multiply/divide/modulo iterate over n cycles on a shared 2n-bit engine.
module alu_secuencial #(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [n-1:0] entrada1,
  input  logic [n-1:0] entrada2,
  input  logic [3:0]   selector,
  output logic [n-1:0] resultado,
  output logic         carry,
  output logic         cero,
  output logic         negativo,
  output logic         desbordamiento,
  output logic         div_cero,
  output logic         listo,
  output logic         ocupado
);

  localparam logic [3:0] OpSuma  = 4'b0001;
  localparam logic [3:0] OpResta = 4'b0010;
  localparam logic [3:0] OpMul   = 4'b0011;
  localparam logic [3:0] OpDiv   = 4'b0100;
  localparam logic [3:0] OpMod   = 4'b0101;
  localparam logic [3:0] OpAnd   = 4'b0110;
  localparam logic [3:0] OpOr    = 4'b0111;
  localparam logic [3:0] OpXor   = 4'b1000;
  localparam logic [3:0] OpSll   = 4'b1001;
  localparam logic [3:0] OpSrl   = 4'b1010;

  localparam int unsigned      CntW    = (n > 2) ? $clog2(n) : 1;
  localparam logic [CntW-1:0]  CntInit = CntW'(n - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [n-1:0]    b_q, b_d;
  logic [n-1:0]    hi_q, hi_d;
  logic [n-1:0]    lo_q, lo_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [n-1:0]    res_q, res_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic            dz_q, dz_d;
  logic            cero_q, neg_q;
  logic            wr_out;

  // Single-cycle datapath, evaluated straight from the inputs in the capture cycle.
  logic [n:0]      sum_ext, dif_ext;
  logic [n-1:0]    single_res;
  logic            single_c, single_v, single_dz;
  logic            is_iter;

  assign sum_ext = {1'b0, entrada1} + {1'b0, entrada2};
  assign dif_ext = {1'b0, entrada1} - {1'b0, entrada2};
  assign is_iter = (selector == OpMul) ||
                   (((selector == OpDiv) || (selector == OpMod)) && (entrada2 != '0));

  always_comb begin
    single_res = '0;
    single_c   = 1'b0;
    single_v   = 1'b0;
    single_dz  = 1'b0;
    case (selector)
      OpSuma: begin
        single_res = sum_ext[n-1:0];
        single_c   = sum_ext[n];
        single_v   = (entrada1[n-1] == entrada2[n-1]) && (sum_ext[n-1] != entrada1[n-1]);
      end
      OpResta: begin
        single_res = dif_ext[n-1:0];
        single_c   = dif_ext[n];
        single_v   = (entrada1[n-1] != entrada2[n-1]) && (dif_ext[n-1] != entrada1[n-1]);
      end
      // Div/mod only take this path when the divisor is zero.
      OpDiv: begin
        single_res = '1;
        single_dz  = 1'b1;
      end
      OpMod: begin
        single_res = entrada1;
        single_dz  = 1'b1;
      end
      OpAnd: single_res = entrada1 & entrada2;
      OpOr:  single_res = entrada1 | entrada2;
      OpXor: single_res = entrada1 ^ entrada2;
      // Shifting by n or more already yields zero at this width.
      OpSll: single_res = entrada1 << entrada2;
      OpSrl: single_res = entrada1 >> entrada2;
      default: ;
    endcase
  end

  // Iteration engine. Multiply: hi accumulates, lo holds the multiplier shifting out to the
  // right. Divide: hi is the partial remainder, lo the dividend shifting left into the quotient.
  logic [n:0]   mul_sum;
  logic [n-1:0] mul_hi, mul_lo;
  logic [n:0]   div_shift;
  logic         div_ge;
  logic [n-1:0] div_hi, div_lo;
  logic [n-1:0] step_hi, step_lo;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign mul_hi    = mul_sum[n:1];
  assign mul_lo    = {mul_sum[0], lo_q[n-1:1]};

  assign div_shift = {hi_q, lo_q[n-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  // Remainder after a successful subtract is below b_q, so n bits suffice.
  assign div_hi    = div_ge ? (div_shift[n-1:0] - b_q) : div_shift[n-1:0];
  assign div_lo    = {lo_q[n-2:0], div_ge};

  assign step_hi   = (op_q == OpMul) ? mul_hi : div_hi;
  assign step_lo   = (op_q == OpMul) ? mul_lo : div_lo;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    wr_out  = 1'b0;
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    dz_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (inicio) begin
          op_d  = selector;
          b_d   = entrada2;
          hi_d  = '0;
          lo_d  = entrada1;
          cnt_d = CntInit;
          if (is_iter) begin
            state_d = StCalc;
          end else begin
            state_d = StFin;
            wr_out  = 1'b1;
            res_d   = single_res;
            carry_d = single_c;
            ovf_d   = single_v;
            dz_d    = single_dz;
          end
        end
      end
      StCalc: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = StFin;
          wr_out  = 1'b1;
          res_d   = (op_q == OpMod) ? step_hi : step_lo;
          carry_d = (op_q == OpMul) && (step_hi != '0);
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      cero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      if (wr_out) begin
        res_q   <= res_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        dz_q    <= dz_d;
        cero_q  <= (res_d == '0);
        neg_q   <= res_d[n-1];
      end
    end
  end

  assign resultado      = res_q;
  assign carry          = carry_q;
  assign cero           = cero_q;
  assign negativo       = neg_q;
  assign desbordamiento = ovf_q;
  assign div_cero       = dz_q;
  assign listo          = (state_q == StFin);
  assign ocupado        = (state_q == StCalc);

endmodule
